// File: rtl/boss_phase_controller.sv
// boss_phase_controller: multi-phase boss life pool, invulnerability/fade windows,
// fire cadence and missile fan mask, sequenced by a per-phase state machine.
module boss_phase_controller #(
    parameter int LIVES_WIDTH       = 5,
    parameter int LIVES_AMOUNT      = 21,
    parameter int LIVES_PER_PHASE   = 7,
    parameter int PHASES            = 3,
    parameter int PHASE_WIDTH       = 2,
    parameter int MAX_MISSILES      = 9,
    parameter int BASE_FAN          = 5,
    parameter int BASE_COOLDOWN     = 90,
    parameter int COOLDOWN_STEP     = 20,
    parameter int MIN_COOLDOWN      = 30,
    parameter int ENTRY_FRAMES      = 32,
    parameter int DAMAGED_FRAMES    = 16,
    parameter int TRANSITION_FRAMES = 48,
    parameter int DEATH_FRAMES      = 64
) (
    input  logic                    clk,
    input  logic                    resetN,
    input  logic                    enable,
    input  logic                    startOfFrame,
    input  logic                    hit,
    output logic                    shooting_pulse,
    output logic                    switch_direction_pulse,
    output logic [MAX_MISSILES-1:0] fan_mask,
    output logic [PHASE_WIDTH-1:0]  phase,
    output logic [LIVES_WIDTH-1:0]  lives,
    output logic                    invulnerable,
    output logic                    faded,
    output logic                    boss_dead
);
    localparam int MAX_AB     = ENTRY_FRAMES > DAMAGED_FRAMES ? ENTRY_FRAMES : DAMAGED_FRAMES;
    localparam int MAX_CD     = TRANSITION_FRAMES > DEATH_FRAMES ? TRANSITION_FRAMES : DEATH_FRAMES;
    localparam int FRAMES_MAX = MAX_AB > MAX_CD ? MAX_AB : MAX_CD;
    localparam int FW         = $clog2(FRAMES_MAX + 1);
    localparam int CW         = $clog2(BASE_COOLDOWN + 1);

    typedef enum logic [2:0] {ENTERING, ACTIVE, DAMAGED, PHASE_TRANSITION, DYING, DEAD} state_t;

    state_t                 state;
    logic [FW-1:0]          cnt;
    logic [CW-1:0]          cd;
    logic                   tick, expire, hit_ok, last_life, boundary, fire;
    logic [LIVES_WIDTH-1:0] new_lives;

    function automatic logic [CW-1:0] cooldown_of(input logic [PHASE_WIDTH-1:0] p);
        int c;
        c = BASE_COOLDOWN - int'(p) * COOLDOWN_STEP;
        return CW'(c < MIN_COOLDOWN ? MIN_COOLDOWN : c);
    endfunction

    function automatic logic [MAX_MISSILES-1:0] mask_of(input logic [PHASE_WIDTH-1:0] p);
        int f;
        logic [MAX_MISSILES-1:0] m;
        f = BASE_FAN + 2 * int'(p);
        if (f > MAX_MISSILES) f = MAX_MISSILES;
        for (int i = 0; i < MAX_MISSILES; i++)
            m[i] = i >= MAX_MISSILES / 2 - f / 2 && i <= MAX_MISSILES / 2 + f / 2;
        return m;
    endfunction

    always_comb begin
        tick      = startOfFrame & enable;
        expire    = tick && cd == CW'(1);
        hit_ok    = hit && enable && state == ACTIVE;
        new_lives = lives - 1'b1;
        last_life = new_lives == '0;
        boundary  = (LIVES_AMOUNT - int'(new_lives)) % LIVES_PER_PHASE == 0 && int'(phase) < PHASES - 1;
        // a hit that ends the phase or the boss swallows a shot due on the same clock
        fire      = (state == ACTIVE || state == DAMAGED) && expire && !(hit_ok && (last_life || boundary));
    end

    assign fan_mask     = mask_of(phase);
    assign invulnerable = state != ACTIVE;
    assign boss_dead    = state == DEAD;
    assign faded        = state == DEAD || (state == DAMAGED && cnt[2]) ||
                          (state == PHASE_TRANSITION && cnt[3]) || (state == DYING && cnt[1]);

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state                  <= ENTERING;
            cnt                    <= FW'(ENTRY_FRAMES);
            cd                     <= '0;
            lives                  <= LIVES_WIDTH'(LIVES_AMOUNT);
            phase                  <= '0;
            shooting_pulse         <= 1'b0;
            switch_direction_pulse <= 1'b0;
        end else begin
            shooting_pulse         <= fire;
            switch_direction_pulse <= fire || (hit_ok && !last_life && boundary);
            if ((state == ACTIVE || state == DAMAGED) && tick)
                cd <= expire ? cooldown_of(phase) : cd - 1'b1;
            case (state)
                ENTERING, DAMAGED, PHASE_TRANSITION, DYING: if (tick) begin
                    cnt <= cnt - 1'b1;
                    if (cnt == FW'(1)) begin
                        state <= state == DYING ? DEAD : ACTIVE;
                        // leaving DAMAGED keeps the running cooldown
                        if (state == ENTERING || state == PHASE_TRANSITION) cd <= cooldown_of(phase);
                    end
                end
                ACTIVE: if (hit_ok) begin
                    lives <= new_lives;
                    if (last_life) begin
                        state <= DYING;
                        cnt   <= FW'(DEATH_FRAMES);
                    end else if (boundary) begin
                        phase <= phase + 1'b1;
                        state <= PHASE_TRANSITION;
                        cnt   <= FW'(TRANSITION_FRAMES);
                    end else begin
                        state <= DAMAGED;
                        cnt   <= FW'(DAMAGED_FRAMES);
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_boss_phase_controller.sv
// tb_boss_phase_controller: scenario tasks with a shot-tick scoreboard for boss_phase_controller.
module tb_boss_phase_controller;
    logic clk = 0, resetN = 0, enable = 1, startOfFrame = 0, hit = 0;
    logic shooting_pulse, switch_direction_pulse, invulnerable, faded, boss_dead;
    logic [8:0] fan_mask;
    logic [1:0] phase;
    logic [4:0] lives;
    int passed = 0, total = 0, tick_count = 0;
    int shot_q[$];

    always #5 clk = ~clk;

    boss_phase_controller dut (
        .clk(clk), .resetN(resetN), .enable(enable), .startOfFrame(startOfFrame), .hit(hit),
        .shooting_pulse(shooting_pulse), .switch_direction_pulse(switch_direction_pulse),
        .fan_mask(fan_mask), .phase(phase), .lives(lives), .invulnerable(invulnerable),
        .faded(faded), .boss_dead(boss_dead)
    );

    // every clock goes through here; any shot pulse is popped against the expected tick
    task automatic step(input logic s, input logic h);
        @(negedge clk);
        startOfFrame = s;
        hit = h;
        @(posedge clk);
        if (s && enable) tick_count++;
        #1;
        if (shooting_pulse) begin
            int want;
            total++;
            if (shot_q.size() == 0) $display("FAIL unexpected_shot at tick %0d", tick_count);
            else begin
                want = shot_q.pop_front();
                if (tick_count !== want) $display("FAIL shot_tick got %0d want %0d", tick_count, want);
                else passed++;
            end
            total++;
            if (switch_direction_pulse !== 1'b1) $display("FAIL shot_switch got %b want 1", switch_direction_pulse);
            else passed++;
        end
    endtask

    task automatic frames(input int n);
        for (int i = 0; i < n; i++) begin
            step(1, 0);
            step(0, 0);
        end
    endtask

    task automatic test_reset;
        resetN = 0;
        repeat (2) @(posedge clk);
        #1;
        total++; if (lives !== 5'd21) $display("FAIL rst_lives got %0d want 21", lives); else passed++;
        total++; if (phase !== 2'd0) $display("FAIL rst_phase got %0d want 0", phase); else passed++;
        total++; if (fan_mask !== 9'h07C) $display("FAIL rst_fan got %h want 07c", fan_mask); else passed++;
        total++; if (invulnerable !== 1'b1) $display("FAIL rst_invuln got %b want 1", invulnerable); else passed++;
        total++; if (shooting_pulse !== 1'b0) $display("FAIL rst_shot got %b want 0", shooting_pulse); else passed++;
        total++; if (switch_direction_pulse !== 1'b0) $display("FAIL rst_switch got %b want 0", switch_direction_pulse); else passed++;
        total++; if (faded !== 1'b0) $display("FAIL rst_faded got %b want 0", faded); else passed++;
        total++; if (boss_dead !== 1'b0) $display("FAIL rst_dead got %b want 0", boss_dead); else passed++;
        @(negedge clk);
        resetN = 1;
        tick_count = 0;
    endtask

    task automatic test_entry_shots;
        frames(31);
        total++; if (invulnerable !== 1'b1) $display("FAIL entry_invuln got %b want 1", invulnerable); else passed++;
        frames(1);
        total++; if (invulnerable !== 1'b0) $display("FAIL entry_active got %b want 0", invulnerable); else passed++;
        shot_q.push_back(tick_count + 90);
        shot_q.push_back(tick_count + 180);
        frames(180);
        total++; if (shot_q.size() !== 0) $display("FAIL entry_shots_pending got %0d want 0", shot_q.size()); else passed++;
        total++; if (fan_mask !== 9'h07C) $display("FAIL entry_fan got %h want 07c", fan_mask); else passed++;
        total++; if (lives !== 5'd21) $display("FAIL entry_lives got %0d want 21", lives); else passed++;
    endtask

    task automatic test_damaged;
        shot_q.push_back(tick_count + 90);
        repeat (5) step(0, 1);
        total++; if (lives !== 5'd20) $display("FAIL dmg_lives got %0d want 20", lives); else passed++;
        total++; if (invulnerable !== 1'b1) $display("FAIL dmg_invuln got %b want 1", invulnerable); else passed++;
        total++; if (faded !== 1'b0) $display("FAIL dmg_faded16 got %b want 0", faded); else passed++;
        frames(1);
        total++; if (faded !== 1'b1) $display("FAIL dmg_faded15 got %b want 1", faded); else passed++;
        frames(4);
        total++; if (faded !== 1'b0) $display("FAIL dmg_faded11 got %b want 0", faded); else passed++;
        frames(4);
        total++; if (faded !== 1'b1) $display("FAIL dmg_faded7 got %b want 1", faded); else passed++;
        frames(6);
        total++; if (invulnerable !== 1'b1) $display("FAIL dmg_invuln1 got %b want 1", invulnerable); else passed++;
        frames(1);
        total++; if (invulnerable !== 1'b0) $display("FAIL dmg_exit got %b want 0", invulnerable); else passed++;
        total++; if (faded !== 1'b0) $display("FAIL dmg_exit_faded got %b want 0", faded); else passed++;
        for (int i = 2; i <= 6; i++) begin
            step(0, 1);
            frames(16);
        end
        total++; if (lives !== 5'd15) $display("FAIL dmg_lives6 got %0d want 15", lives); else passed++;
        total++; if (shot_q.size() !== 0) $display("FAIL dmg_shot_pending got %0d want 0", shot_q.size()); else passed++;
    endtask

    task automatic test_phase1;
        step(0, 1);
        total++; if (lives !== 5'd14) $display("FAIL ph1_lives got %0d want 14", lives); else passed++;
        total++; if (phase !== 2'd1) $display("FAIL ph1_phase got %0d want 1", phase); else passed++;
        total++; if (fan_mask !== 9'h0FE) $display("FAIL ph1_fan got %h want 0fe", fan_mask); else passed++;
        total++; if (switch_direction_pulse !== 1'b1) $display("FAIL ph1_switch got %b want 1", switch_direction_pulse); else passed++;
        total++; if (shooting_pulse !== 1'b0) $display("FAIL ph1_shot got %b want 0", shooting_pulse); else passed++;
        step(0, 0);
        total++; if (switch_direction_pulse !== 1'b0) $display("FAIL ph1_switch_once got %b want 0", switch_direction_pulse); else passed++;
        frames(1);
        total++; if (faded !== 1'b1) $display("FAIL ph1_faded47 got %b want 1", faded); else passed++;
        frames(46);
        total++; if (invulnerable !== 1'b1) $display("FAIL ph1_invuln got %b want 1", invulnerable); else passed++;
        frames(1);
        total++; if (invulnerable !== 1'b0) $display("FAIL ph1_active got %b want 0", invulnerable); else passed++;
        shot_q.push_back(tick_count + 70);
        shot_q.push_back(tick_count + 140);
        frames(140);
        total++; if (shot_q.size() !== 0) $display("FAIL ph1_shot_pending got %0d want 0", shot_q.size()); else passed++;
    endtask

    task automatic test_phase2_suppress;
        int base;
        base = tick_count;
        shot_q.push_back(base + 70);
        for (int i = 8; i <= 13; i++) begin
            step(0, 1);
            frames(16);
        end
        frames(base + 139 - tick_count);
        step(1, 1);
        total++; if (tick_count !== base + 140) $display("FAIL ph2_align got %0d want %0d", tick_count, base + 140); else passed++;
        total++; if (shooting_pulse !== 1'b0) $display("FAIL ph2_suppressed got %b want 0", shooting_pulse); else passed++;
        total++; if (switch_direction_pulse !== 1'b1) $display("FAIL ph2_switch got %b want 1", switch_direction_pulse); else passed++;
        total++; if (phase !== 2'd2) $display("FAIL ph2_phase got %0d want 2", phase); else passed++;
        total++; if (fan_mask !== 9'h1FF) $display("FAIL ph2_fan got %h want 1ff", fan_mask); else passed++;
        total++; if (lives !== 5'd7) $display("FAIL ph2_lives got %0d want 7", lives); else passed++;
        step(0, 0);
        frames(48);
        shot_q.push_back(tick_count + 50);
        frames(50);
        total++; if (shot_q.size() !== 0) $display("FAIL ph2_shot_pending got %0d want 0", shot_q.size()); else passed++;
    endtask

    task automatic test_simultaneous_damaged;
        int base;
        base = tick_count;
        shot_q.push_back(base + 50);
        shot_q.push_back(base + 100);
        frames(49);
        step(1, 1);
        total++; if (lives !== 5'd6) $display("FAIL sim_lives got %0d want 6", lives); else passed++;
        total++; if (invulnerable !== 1'b1) $display("FAIL sim_damaged got %b want 1", invulnerable); else passed++;
        total++; if (phase !== 2'd2) $display("FAIL sim_phase got %0d want 2", phase); else passed++;
        step(0, 0);
        frames(16);
        for (int i = 16; i <= 20; i++) begin
            step(0, 1);
            frames(16);
        end
        total++; if (lives !== 5'd1) $display("FAIL sim_lives20 got %0d want 1", lives); else passed++;
        total++; if (shot_q.size() !== 0) $display("FAIL sim_shot_pending got %0d want 0", shot_q.size()); else passed++;
    endtask

    task automatic test_death;
        step(0, 1);
        total++; if (lives !== 5'd0) $display("FAIL die_lives got %0d want 0", lives); else passed++;
        total++; if (boss_dead !== 1'b0) $display("FAIL die_not_dead got %b want 0", boss_dead); else passed++;
        frames(1);
        total++; if (faded !== 1'b1) $display("FAIL die_faded63 got %b want 1", faded); else passed++;
        frames(62);
        total++; if (boss_dead !== 1'b0) $display("FAIL die_dying got %b want 0", boss_dead); else passed++;
        frames(1);
        total++; if (boss_dead !== 1'b1) $display("FAIL die_dead got %b want 1", boss_dead); else passed++;
        total++; if (faded !== 1'b1) $display("FAIL die_faded got %b want 1", faded); else passed++;
        repeat (3) step(0, 1);
        frames(100);
        total++; if (lives !== 5'd0) $display("FAIL dead_lives got %0d want 0", lives); else passed++;
        total++; if (boss_dead !== 1'b1) $display("FAIL dead_sticky got %b want 1", boss_dead); else passed++;
    endtask

    task automatic test_async_reset;
        @(negedge clk);
        #2 resetN = 0;
        #1;
        total++; if (lives !== 5'd21) $display("FAIL arst_lives got %0d want 21", lives); else passed++;
        total++; if (boss_dead !== 1'b0) $display("FAIL arst_dead got %b want 0", boss_dead); else passed++;
        total++; if (invulnerable !== 1'b1) $display("FAIL arst_invuln got %b want 1", invulnerable); else passed++;
        total++; if (faded !== 1'b0) $display("FAIL arst_faded got %b want 0", faded); else passed++;
        total++; if (fan_mask !== 9'h07C) $display("FAIL arst_fan got %h want 07c", fan_mask); else passed++;
        total++; if (phase !== 2'd0) $display("FAIL arst_phase got %0d want 0", phase); else passed++;
        @(negedge clk);
        resetN = 1;
        tick_count = 0;
    endtask

    task automatic test_enable_freeze;
        frames(32);
        shot_q.push_back(tick_count + 90);
        frames(50);
        enable = 0;
        frames(100);
        repeat (3) step(0, 1);
        total++; if (lives !== 5'd21) $display("FAIL frz_lives got %0d want 21", lives); else passed++;
        total++; if (invulnerable !== 1'b0) $display("FAIL frz_state got %b want 0", invulnerable); else passed++;
        enable = 1;
        frames(39);
        total++; if (shot_q.size() !== 1) $display("FAIL frz_early_shot got %0d want 1", shot_q.size()); else passed++;
        frames(1);
        total++; if (shot_q.size() !== 0) $display("FAIL frz_shot_pending got %0d want 0", shot_q.size()); else passed++;
    endtask

    initial begin
        test_reset;
        test_entry_shots;
        test_damaged;
        test_phase1;
        test_phase2_suppress;
        test_simultaneous_damaged;
        test_death;
        test_async_reset;
        test_enable_freeze;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
